// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and unified-memory port around mem_port_arbiter.
// slave is the arbiter's view; master is the view of the core stages plus RAM that surround it.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_rerr;

    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_rerr;

    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;

    logic        busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_ack, m_rdata,
        output i_gnt, i_rvalid, i_rdata, i_rerr, d_gnt, d_rvalid, d_rdata, d_rerr,
        output m_req, m_we, m_be, m_addr, m_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_ack, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, i_rerr, d_gnt, d_rvalid, d_rdata, d_rerr,
        input  m_req, m_we, m_be, m_addr, m_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin I/D sharing of one req/ack memory port; gnt 1 cycle after req, rvalid 1 cycle after ack.
// One access in flight; requesters hold req until gnt, optional watchdog aborts unacked accesses.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              resetn,
    mem_port_arbiter_if.slave bus
);
    localparam logic [7:0] TMO     = TIMEOUT[7:0];
    localparam bit         WDOG_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MEM = 2'd1, ST_RESP = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        last_is_d_q, last_is_d_d;
    logic        own_is_d_q, own_is_d_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
    logic        i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic        i_rerr_q, i_rerr_d, d_rerr_q, d_rerr_d;
    logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic        m_req_q, m_req_d, m_we_q, m_we_d;
    logic [3:0]  m_be_q, m_be_d;
    logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
    logic        busy_q, busy_d;
    logic        pick_d, rsp_fire, rsp_err;
    logic [31:0] rsp_dat;

    always_comb begin
        state_d     = state_q;
        last_is_d_d = last_is_d_q;
        own_is_d_d  = own_is_d_q;
        cnt_d       = cnt_q;
        i_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        i_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        i_rerr_d    = 1'b0;
        d_rerr_d    = 1'b0;
        i_rdata_d   = '0;
        d_rdata_d   = '0;
        m_req_d     = m_req_q;
        m_we_d      = m_we_q;
        m_be_d      = m_be_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        rsp_fire    = 1'b0;
        rsp_err     = 1'b0;
        rsp_dat     = '0;
        // D wins only when alone, or on a tie when I was served last
        pick_d      = bus.d_req && (!bus.i_req || !last_is_d_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    state_d     = ST_MEM;
                    last_is_d_d = pick_d;
                    own_is_d_d  = pick_d;
                    cnt_d       = '0;
                    m_req_d     = 1'b1;
                    i_gnt_d     = !pick_d;
                    d_gnt_d     = pick_d;
                    if (pick_d) begin
                        m_we_d    = bus.d_we;
                        m_be_d    = bus.d_be;
                        m_addr_d  = bus.d_addr & 32'hFFFF_FFFC;
                        m_wdata_d = bus.d_wdata;
                    end else begin
                        m_we_d    = 1'b0;
                        m_be_d    = 4'hF;
                        m_addr_d  = bus.i_addr & 32'hFFFF_FFFC;
                        m_wdata_d = '0;
                    end
                end
            end
            ST_MEM: begin
                // A late ack in the final watchdog cycle still completes normally
                if (bus.m_ack) begin
                    rsp_fire = 1'b1;
                    rsp_dat  = m_we_q ? 32'h0 : bus.m_rdata;
                end else if (WDOG_EN && (cnt_q == TMO)) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (rsp_fire) begin
            state_d    = ST_RESP;
            m_req_d    = 1'b0;
            i_rvalid_d = !own_is_d_q;
            d_rvalid_d = own_is_d_q;
            i_rdata_d  = own_is_d_q ? 32'h0 : rsp_dat;
            d_rdata_d  = own_is_d_q ? rsp_dat : 32'h0;
            i_rerr_d   = !own_is_d_q && rsp_err;
            d_rerr_d   = own_is_d_q && rsp_err;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            last_is_d_q <= 1'b1;
            own_is_d_q  <= 1'b0;
            cnt_q       <= '0;
            i_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_rerr_q    <= 1'b0;
            d_rerr_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            m_req_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_be_q      <= '0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_is_d_q <= last_is_d_d;
            own_is_d_q  <= own_is_d_d;
            cnt_q       <= cnt_d;
            i_gnt_q     <= i_gnt_d;
            d_gnt_q     <= d_gnt_d;
            i_rvalid_q  <= i_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            i_rerr_q    <= i_rerr_d;
            d_rerr_q    <= d_rerr_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            m_req_q     <= m_req_d;
            m_we_q      <= m_we_d;
            m_be_q      <= m_be_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.i_gnt    = i_gnt_q;
    assign bus.d_gnt    = d_gnt_q;
    assign bus.i_rvalid = i_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.i_rdata  = i_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.i_rerr   = i_rerr_q;
    assign bus.d_rerr   = d_rerr_q;
    assign bus.m_req    = m_req_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_be     = m_be_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiters (watchdog 16 and 3) driven by directed and random transactions, each response
// predicted from a transaction-level model: round-robin winner, ack latency versus timeout.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        i_req [2];
    logic [31:0] i_addr [2];
    logic        d_req [2];
    logic        d_we [2];
    logic [3:0]  d_be [2];
    logic [31:0] d_addr [2];
    logic [31:0] d_wdata [2];

    logic        i_gnt [2];
    logic        i_rvalid [2];
    logic [31:0] i_rdata [2];
    logic        i_rerr [2];
    logic        d_gnt [2];
    logic        d_rvalid [2];
    logic [31:0] d_rdata [2];
    logic        d_rerr [2];
    logic        m_req [2];
    logic        m_we [2];
    logic [3:0]  m_be [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic        busy [2];

    int          ack_lat [2];
    logic [31:0] rd_val [2];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter_if ifc ();
        logic        ack;
        logic [31:0] rdat;

        mem_port_arbiter #(.TIMEOUT(g == 0 ? 16 : 3)) u_dut (
            .clk    (clk),
            .resetn (resetn),
            .bus    (ifc.slave)
        );

        assign ifc.i_req   = i_req[g];
        assign ifc.i_addr  = i_addr[g];
        assign ifc.d_req   = d_req[g];
        assign ifc.d_we    = d_we[g];
        assign ifc.d_be    = d_be[g];
        assign ifc.d_addr  = d_addr[g];
        assign ifc.d_wdata = d_wdata[g];
        assign ifc.m_ack   = ack;
        assign ifc.m_rdata = rdat;

        assign i_gnt[g]    = ifc.i_gnt;
        assign i_rvalid[g] = ifc.i_rvalid;
        assign i_rdata[g]  = ifc.i_rdata;
        assign i_rerr[g]   = ifc.i_rerr;
        assign d_gnt[g]    = ifc.d_gnt;
        assign d_rvalid[g] = ifc.d_rvalid;
        assign d_rdata[g]  = ifc.d_rdata;
        assign d_rerr[g]   = ifc.d_rerr;
        assign m_req[g]    = ifc.m_req;
        assign m_we[g]     = ifc.m_we;
        assign m_be[g]     = ifc.m_be;
        assign m_addr[g]   = ifc.m_addr;
        assign m_wdata[g]  = ifc.m_wdata;
        assign busy[g]     = ifc.busy;

        // RAM model: acks in the (ack_lat+1)-th cycle that m_req is seen high
        initial begin : ram
            int w;
            w    = 0;
            ack  = 1'b0;
            rdat = '0;
            forever begin
                @(negedge clk);
                if (m_req[g] === 1'b1) begin
                    ack  = (w == ack_lat[g]);
                    rdat = rd_val[g];
                    w++;
                end else begin
                    ack = 1'b0;
                    w   = 0;
                end
            end
        end
    end

    // Reference state: which port each arbiter granted last (1 = D)
    bit last_d [2];

    function automatic int tmo(input int s);
        return (s == 0) ? 16 : 3;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input int s, input string tag);
        chk1({tag, "_m_req"}, m_req[s], 1'b0);
        chk1({tag, "_busy"}, busy[s], 1'b0);
        chk1({tag, "_i_gnt"}, i_gnt[s], 1'b0);
        chk1({tag, "_d_gnt"}, d_gnt[s], 1'b0);
        chk1({tag, "_i_rvalid"}, i_rvalid[s], 1'b0);
        chk1({tag, "_d_rvalid"}, d_rvalid[s], 1'b0);
    endtask

    // Called at a falling edge while the arbiter is idle; returns at the falling edge of its next idle cycle
    task automatic txn(input int s, input bit ri, input bit rd, input bit we, input logic [3:0] be,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                       input logic [31:0] rdv, input int lat);
        bit          win_d, acked, spur, stable, ewe;
        logic [31:0] ea, edat;
        logic [3:0]  ebe;
        logic [68:0] pay;
        int          n, mc, exp_mc;

        win_d     = rd && !(ri && last_d[s]);
        last_d[s] = win_d;
        ea        = (win_d ? da : ia) & 32'hFFFF_FFFC;
        ebe       = win_d ? be : 4'hF;
        ewe       = win_d && we;
        acked     = (tmo(s) == 0) || (lat <= tmo(s));
        exp_mc    = acked ? lat + 1 : tmo(s) + 1;
        edat      = (acked && !ewe) ? rdv : 32'h0;

        ack_lat[s] = lat;
        rd_val[s]  = rdv;
        i_req[s]   = ri;
        i_addr[s]  = ia;
        d_req[s]   = rd;
        d_we[s]    = we;
        d_be[s]    = be;
        d_addr[s]  = da;
        d_wdata[s] = wd;

        n    = 0;
        spur = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (i_rvalid[s] !== 1'b0 || d_rvalid[s] !== 1'b0) spur = 1'b1;
        end while (i_gnt[s] !== 1'b1 && d_gnt[s] !== 1'b1 && n < 20);
        chk1("no_rvalid_before_gnt", spur, 1'b0);
        chk32("gnt_latency", 32'(n), 32'd1);
        chk1("i_gnt", i_gnt[s], !win_d);
        chk1("d_gnt", d_gnt[s], win_d);
        chk1("m_req_at_gnt", m_req[s], 1'b1);
        chk1("busy_at_gnt", busy[s], 1'b1);
        chk32("m_addr", m_addr[s], ea);
        chk32("m_be", 32'(m_be[s]), 32'(ebe));
        chk1("m_we", m_we[s], ewe);
        if (win_d) chk32("m_wdata", m_wdata[s], wd);

        pay = {m_we[s], m_be[s], m_addr[s], m_wdata[s]};
        if (win_d) d_req[s] = 1'b0;
        else       i_req[s] = 1'b0;

        mc     = 1;
        stable = 1'b1;
        while (mc < 300) begin
            @(negedge clk);
            if (m_req[s] !== 1'b1) break;
            mc++;
            if ({m_we[s], m_be[s], m_addr[s], m_wdata[s]} !== pay) stable = 1'b0;
            if (i_gnt[s] !== 1'b0 || d_gnt[s] !== 1'b0) stable = 1'b0;
        end
        chk1("payload_stable", stable, 1'b1);
        chk32("m_req_cycles", 32'(mc), 32'(exp_mc));

        chk1("i_rvalid", i_rvalid[s], !win_d);
        chk1("d_rvalid", d_rvalid[s], win_d);
        chk1("gnt_low_in_resp", i_gnt[s] | d_gnt[s], 1'b0);
        chk32("i_rdata", i_rdata[s], win_d ? 32'h0 : edat);
        chk32("d_rdata", d_rdata[s], win_d ? edat : 32'h0);
        chk1("i_rerr", i_rerr[s], !win_d && !acked);
        chk1("d_rerr", d_rerr[s], win_d && !acked);

        @(negedge clk);
        chk_quiet(s, "after_resp");
        i_req[s] = 1'b0;
        d_req[s] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "time limit");
    end

    initial begin
        resetn = 1'b0;
        for (int s = 0; s < 2; s++) begin
            i_req[s] = 0; i_addr[s] = 0; d_req[s] = 0; d_we[s] = 0;
            d_be[s] = 0; d_addr[s] = 0; d_wdata[s] = 0;
            ack_lat[s] = 0; rd_val[s] = 0;
            last_d[s] = 1'b1;
        end

        // Reset state
        #2;
        for (int s = 0; s < 2; s++) begin
            chk_quiet(s, "reset");
            chk32("reset_m_addr", m_addr[s], 32'h0);
            chk32("reset_i_rdata", i_rdata[s], 32'h0);
            chk32("reset_d_rdata", d_rdata[s], 32'h0);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Tie held continuously: I, D, I, D
        for (int k = 0; k < 4; k++)
            txn(0, 1, 1, k[0], 4'hF, 32'h1000_0000 + 32'(k * 4), 32'h2000_0001 + 32'(k * 8),
                32'hA5A5_0000 + 32'(k), 32'h1111_0000 + 32'(k), 0);

        // Single fetch, zero-wait memory
        txn(0, 1, 0, 0, 4'h0, 32'h8000_0006, 32'h0, 32'h0, 32'h0000_0513, 0);

        // Store with four wait states
        txn(0, 0, 1, 1, 4'b0011, 32'h0, 32'h0000_0102, 32'hDEAD_BEEF, 32'h5555_AAAA, 4);

        // Watchdog 3: no ack, then a normal access, then both sides of the boundary
        txn(1, 0, 1, 0, 4'hF, 32'h0, 32'h0000_0040, 32'h0, 32'h7777_7777, 1000);
        txn(1, 0, 1, 0, 4'hF, 32'h0, 32'h0000_0044, 32'h0, 32'h1234_5678, 1);
        txn(1, 1, 0, 0, 4'hF, 32'h0000_0103, 32'h0, 32'h0, 32'hCAFE_F00D, 3);
        txn(1, 1, 0, 0, 4'hF, 32'h0000_0107, 32'h0, 32'h0, 32'hCAFE_F00D, 4);

        // Reset during MEM abandons the access; I wins the first tie afterwards
        ack_lat[0] = 1000;
        i_req[0]   = 1'b1;
        i_addr[0]  = 32'h0000_0200;
        repeat (3) @(negedge clk);
        chk1("pre_reset_m_req", m_req[0], 1'b1);
        #2 resetn = 1'b0;
        d_req[0] = 1'b1;
        #1;
        chk_quiet(0, "async_reset");
        chk_quiet(1, "async_reset_b");
        last_d[0] = 1'b1;
        last_d[1] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk1("in_reset_i_rvalid", i_rvalid[0], 1'b0);
            chk1("in_reset_d_rvalid", d_rvalid[0], 1'b0);
        end
        resetn = 1'b1;
        txn(0, 1, 1, 0, 4'hF, 32'h0000_0200, 32'h0000_0300, 32'h0, 32'h0BAD_CAFE, 2);

        // Random traffic on both arbiters
        for (int k = 0; k < 60; k++) begin
            int          s, sel, lat;
            logic [31:0] rnd;
            s   = k % 2;
            sel = $urandom_range(0, 2);
            lat = (s == 0) ? $urandom_range(0, 6) : $urandom_range(0, 5);
            rnd = $urandom;
            txn(s, sel != 1, sel != 0, rnd[0], rnd[7:4], $urandom, $urandom, $urandom, $urandom, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
